// File: rtl/cond_exec_stage.sv
// Decode->Execute pipeline register with ARM-style conditional execution.
// Holds the decoded control word for the instruction in Execute and evaluates
// its condition field against the architectural NZCV flags. It gates every
// state-changing control on that result and owns the NZCV and halt state.
module cond_exec_stage #(
  parameter logic [3:0] FLAG_RST    = 4'b0000,
  parameter bit         HALT_STICKY = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       StallE,
  input  logic       FlushE,
  input  logic       PCSrcD,
  input  logic       RegWriteD,
  input  logic       MemtoRegD,
  input  logic       MemWriteD,
  input  logic       BranchD,
  input  logic       ALUSrcD,
  input  logic       Stuck,
  input  logic [2:0] ALUControlD,
  input  logic [1:0] FlagWriteD,
  input  logic [3:0] CondD,
  input  logic [3:0] ALUFlags,
  output logic       PCSrcE,
  output logic       RegWriteE,
  output logic       MemWriteE,
  output logic       MemtoRegE,
  output logic       ALUSrcE,
  output logic [2:0] ALUControlE,
  output logic       BranchTakenE,
  output logic       CondExE,
  output logic [3:0] FlagsE,
  output logic       HaltE
);

  localparam logic [3:0] COND_AL = 4'b1110;

  logic       pcsrc_reg;
  logic       regwrite_reg;
  logic       memtoreg_reg;
  logic       memwrite_reg;
  logic       branch_reg;
  logic       alusrc_reg;
  logic       stuck_reg;
  logic [2:0] alucontrol_reg;
  logic [1:0] flagwrite_reg;
  logic [3:0] cond_reg;
  logic [3:0] flags_reg;
  logic       halt_reg;
  logic       cond_ex;
  logic       flag_we;
  logic       n_flag, z_flag, c_flag, v_flag;

  assign {n_flag, z_flag, c_flag, v_flag} = flags_reg;

  // Evaluate the condition field of the instruction in E against current flags.
  always_comb begin
    cond_ex = 1'b0;
    case (cond_reg)
      4'b0000: cond_ex = z_flag;
      4'b0001: cond_ex = ~z_flag;
      4'b0010: cond_ex = c_flag;
      4'b0011: cond_ex = ~c_flag;
      4'b0100: cond_ex = n_flag;
      4'b0101: cond_ex = ~n_flag;
      4'b0110: cond_ex = v_flag;
      4'b0111: cond_ex = ~v_flag;
      4'b1000: cond_ex = c_flag & ~z_flag;
      4'b1001: cond_ex = ~c_flag | z_flag;
      4'b1010: cond_ex = (n_flag == v_flag);
      4'b1011: cond_ex = (n_flag != v_flag);
      4'b1100: cond_ex = ~z_flag & (n_flag == v_flag);
      4'b1101: cond_ex = z_flag | (n_flag != v_flag);
      default: cond_ex = 1'b1;
    endcase
  end

  // A stalled instruction must not write flags, otherwise it would update them
  // once per stalled cycle; it writes on the cycle it finally leaves E.
  assign flag_we = cond_ex & ~StallE & ~halt_reg;

  // E pipeline register: flush/halt load a bubble, stall holds, else capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pcsrc_reg      <= 1'b0;
      regwrite_reg   <= 1'b0;
      memtoreg_reg   <= 1'b0;
      memwrite_reg   <= 1'b0;
      branch_reg     <= 1'b0;
      alusrc_reg     <= 1'b0;
      stuck_reg      <= 1'b0;
      alucontrol_reg <= 3'b000;
      flagwrite_reg  <= 2'b00;
      cond_reg       <= 4'b0000;
    end else if (FlushE || halt_reg) begin
      pcsrc_reg      <= 1'b0;
      regwrite_reg   <= 1'b0;
      memtoreg_reg   <= 1'b0;
      memwrite_reg   <= 1'b0;
      branch_reg     <= 1'b0;
      alusrc_reg     <= 1'b0;
      stuck_reg      <= 1'b0;
      alucontrol_reg <= 3'b000;
      flagwrite_reg  <= 2'b00;
      cond_reg       <= COND_AL;
    end else if (!StallE) begin
      pcsrc_reg      <= PCSrcD;
      regwrite_reg   <= RegWriteD;
      memtoreg_reg   <= MemtoRegD;
      memwrite_reg   <= MemWriteD;
      branch_reg     <= BranchD;
      alusrc_reg     <= ALUSrcD;
      stuck_reg      <= Stuck;
      alucontrol_reg <= ALUControlD;
      flagwrite_reg  <= FlagWriteD;
      cond_reg       <= CondD;
    end
  end

  // NZCV register: N,Z and C,V are written independently by FlagWrite bits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flags_reg <= FLAG_RST;
    end else begin
      if (flag_we && flagwrite_reg[1]) flags_reg[3:2] <= ALUFlags[3:2];
      if (flag_we && flagwrite_reg[0]) flags_reg[1:0] <= ALUFlags[1:0];
    end
  end

  // Halt: set when a Stuck instruction executes. In non-sticky mode the halt
  // releases once the decoder presents a non-Stuck word that would be captured
  // (E itself only holds bubbles while halted, so it cannot be the trigger).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      halt_reg <= 1'b0;
    end else if (stuck_reg && cond_ex && !StallE) begin
      halt_reg <= 1'b1;
    end else if (!HALT_STICKY && halt_reg && !StallE && !FlushE && !Stuck) begin
      halt_reg <= 1'b0;
    end
  end

  assign CondExE      = cond_ex;
  assign RegWriteE    = regwrite_reg & cond_ex & ~halt_reg;
  assign MemWriteE    = memwrite_reg & cond_ex & ~halt_reg;
  assign PCSrcE       = pcsrc_reg & cond_ex & ~halt_reg;
  assign BranchTakenE = branch_reg & cond_ex & ~halt_reg;
  assign MemtoRegE    = memtoreg_reg;
  assign ALUSrcE      = alusrc_reg;
  assign ALUControlE  = alucontrol_reg;
  assign FlagsE       = flags_reg;
  assign HaltE        = halt_reg;

endmodule

// File: tb/tb_cond_exec_stage.sv
// Directed testbench for cond_exec_stage: reset, condition gating, flag
// writes, stall, flush and halt scenarios with hand-computed expectations.
module tb_cond_exec_stage;

  logic       clk;
  logic       rst_n;
  logic       StallE, FlushE;
  logic       PCSrcD, RegWriteD, MemtoRegD, MemWriteD, BranchD, ALUSrcD, Stuck;
  logic [2:0] ALUControlD;
  logic [1:0] FlagWriteD;
  logic [3:0] CondD;
  logic [3:0] ALUFlags;
  logic       PCSrcE, RegWriteE, MemWriteE, MemtoRegE, ALUSrcE;
  logic [2:0] ALUControlE;
  logic       BranchTakenE, CondExE, HaltE;
  logic [3:0] FlagsE;

  int n_checks = 0;
  int n_fail   = 0;

  cond_exec_stage #(.FLAG_RST(4'b0000), .HALT_STICKY(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .StallE(StallE), .FlushE(FlushE),
    .PCSrcD(PCSrcD), .RegWriteD(RegWriteD), .MemtoRegD(MemtoRegD),
    .MemWriteD(MemWriteD), .BranchD(BranchD), .ALUSrcD(ALUSrcD), .Stuck(Stuck),
    .ALUControlD(ALUControlD), .FlagWriteD(FlagWriteD), .CondD(CondD),
    .ALUFlags(ALUFlags), .PCSrcE(PCSrcE), .RegWriteE(RegWriteE),
    .MemWriteE(MemWriteE), .MemtoRegE(MemtoRegE), .ALUSrcE(ALUSrcE),
    .ALUControlE(ALUControlE), .BranchTakenE(BranchTakenE), .CondExE(CondExE),
    .FlagsE(FlagsE), .HaltE(HaltE)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock and settle just after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present a decode-stage control word.
  task automatic set_d(input logic pcsrc, input logic regwrite, input logic memtoreg,
                       input logic memwrite, input logic branch, input logic alusrc,
                       input logic stuck, input logic [2:0] aluctl,
                       input logic [1:0] fw, input logic [3:0] cond);
    PCSrcD = pcsrc; RegWriteD = regwrite; MemtoRegD = memtoreg; MemWriteD = memwrite;
    BranchD = branch; ALUSrcD = alusrc; Stuck = stuck; ALUControlD = aluctl;
    FlagWriteD = fw; CondD = cond;
  endtask

  task automatic test_reset();
    set_d(0, 1, 0, 0, 0, 0, 0, 3'b101, 2'b11, 4'b1110);
    ALUFlags = 4'b1111;
    step();
    step();
    n_checks++; if (FlagsE !== 4'b1111) begin n_fail++; $display("FAIL pre_reset_flags actual=%b required=1111", FlagsE); end
    n_checks++; if (RegWriteE !== 1'b1) begin n_fail++; $display("FAIL pre_reset_regwrite actual=%b required=1", RegWriteE); end
    #2 rst_n = 1'b0;
    #1;
    n_checks++; if (FlagsE !== 4'b0000) begin n_fail++; $display("FAIL reset_flags actual=%b required=0000", FlagsE); end
    n_checks++; if ({PCSrcE, RegWriteE, MemWriteE, MemtoRegE, ALUSrcE, BranchTakenE, CondExE, HaltE} !== 8'h00)
      begin n_fail++; $display("FAIL reset_outputs actual=%b required=00000000",
        {PCSrcE, RegWriteE, MemWriteE, MemtoRegE, ALUSrcE, BranchTakenE, CondExE, HaltE}); end
    n_checks++; if (ALUControlE !== 3'b000) begin n_fail++; $display("FAIL reset_aluctl actual=%b required=000", ALUControlE); end
    set_d(0, 0, 0, 0, 0, 0, 0, 3'b000, 2'b00, 4'b1110);
    #2 rst_n = 1'b1;
    $display("test_reset done: FlagsE=%b HaltE=%b", FlagsE, HaltE);
  endtask

  task automatic test_cond_gating();
    set_d(0, 0, 0, 0, 0, 0, 0, 3'b000, 2'b11, 4'b1110);
    ALUFlags = 4'b0100;
    step();
    step();
    n_checks++; if (FlagsE !== 4'b0100) begin n_fail++; $display("FAIL setup_z_flags actual=%b required=0100", FlagsE); end
    set_d(0, 1, 0, 0, 0, 0, 0, 3'b101, 2'b00, 4'b0000);   // EQ, passes with Z=1
    step();
    n_checks++; if (RegWriteE !== 1'b1) begin n_fail++; $display("FAIL eq_regwrite actual=%b required=1", RegWriteE); end
    n_checks++; if (CondExE !== 1'b1) begin n_fail++; $display("FAIL eq_condex actual=%b required=1", CondExE); end
    n_checks++; if (ALUControlE !== 3'b101) begin n_fail++; $display("FAIL eq_aluctl actual=%b required=101", ALUControlE); end
    set_d(1, 1, 1, 1, 1, 1, 0, 3'b010, 2'b00, 4'b0001);   // NE, fails with Z=1
    step();
    n_checks++; if (RegWriteE !== 1'b0) begin n_fail++; $display("FAIL ne_regwrite actual=%b required=0", RegWriteE); end
    n_checks++; if (CondExE !== 1'b0) begin n_fail++; $display("FAIL ne_condex actual=%b required=0", CondExE); end
    n_checks++; if ({PCSrcE, MemWriteE, BranchTakenE} !== 3'b000) begin n_fail++; $display("FAIL ne_gated actual=%b required=000", {PCSrcE, MemWriteE, BranchTakenE}); end
    n_checks++; if ({MemtoRegE, ALUSrcE} !== 2'b11) begin n_fail++; $display("FAIL ne_ungated actual=%b required=11", {MemtoRegE, ALUSrcE}); end
    set_d(0, 0, 0, 1, 0, 0, 0, 3'b000, 2'b00, 4'b1100);   // GT, fails with Z=1
    step();
    n_checks++; if (MemWriteE !== 1'b0) begin n_fail++; $display("FAIL gt_memwrite actual=%b required=0", MemWriteE); end
    set_d(0, 0, 0, 1, 0, 0, 0, 3'b000, 2'b00, 4'b1101);   // LE, passes with Z=1
    step();
    n_checks++; if (MemWriteE !== 1'b1) begin n_fail++; $display("FAIL le_memwrite actual=%b required=1", MemWriteE); end
    $display("test_cond_gating done: FlagsE=%b", FlagsE);
  endtask

  task automatic test_flags();
    set_d(0, 0, 0, 0, 0, 0, 0, 3'b000, 2'b11, 4'b1110);
    ALUFlags = 4'b1010;
    step();
    n_checks++; if (FlagsE !== 4'b0100) begin n_fail++; $display("FAIL flags_pre_update actual=%b required=0100", FlagsE); end
    step();
    n_checks++; if (FlagsE !== 4'b1010) begin n_fail++; $display("FAIL flags_full_write actual=%b required=1010", FlagsE); end
    ALUFlags = 4'b0001;
    step();
    n_checks++; if (FlagsE !== 4'b0001) begin n_fail++; $display("FAIL flags_setup_0001 actual=%b required=0001", FlagsE); end
    set_d(0, 0, 0, 0, 0, 0, 0, 3'b000, 2'b10, 4'b1110);   // write N,Z only
    step();
    ALUFlags = 4'b1010;
    set_d(0, 0, 0, 0, 0, 0, 0, 3'b000, 2'b00, 4'b1110);
    step();
    n_checks++; if (FlagsE !== 4'b1001) begin n_fail++; $display("FAIL flags_nz_only actual=%b required=1001", FlagsE); end
    set_d(0, 0, 0, 0, 0, 0, 0, 3'b000, 2'b11, 4'b1011);   // LT fails with N=V=1
    ALUFlags = 4'b0000;
    step();
    n_checks++; if (CondExE !== 1'b0) begin n_fail++; $display("FAIL lt_condex actual=%b required=0", CondExE); end
    step();
    n_checks++; if (FlagsE !== 4'b1001) begin n_fail++; $display("FAIL flags_cond_fail actual=%b required=1001", FlagsE); end
    $display("test_flags done: FlagsE=%b", FlagsE);
  endtask

  task automatic test_stall();
    set_d(0, 1, 0, 0, 0, 0, 0, 3'b011, 2'b11, 4'b1110);
    ALUFlags = 4'b0110;
    step();
    n_checks++; if (FlagsE !== 4'b1001) begin n_fail++; $display("FAIL stall_setup_flags actual=%b required=1001", FlagsE); end
    StallE = 1'b1;
    set_d(0, 0, 0, 1, 0, 0, 0, 3'b110, 2'b00, 4'b1110);
    for (int i = 0; i < 3; i++) begin
      step();
      n_checks++; if (FlagsE !== 4'b1001) begin n_fail++; $display("FAIL stall_flags cyc=%0d actual=%b required=1001", i, FlagsE); end
      n_checks++; if ({RegWriteE, MemWriteE, ALUControlE} !== 5'b10011) begin n_fail++; $display("FAIL stall_hold cyc=%0d actual=%b required=10011", i, {RegWriteE, MemWriteE, ALUControlE}); end
    end
    StallE = 1'b0;
    step();
    n_checks++; if (FlagsE !== 4'b0110) begin n_fail++; $display("FAIL stall_release_flags actual=%b required=0110", FlagsE); end
    n_checks++; if ({RegWriteE, MemWriteE, ALUControlE} !== 5'b01110) begin n_fail++; $display("FAIL stall_release_capture actual=%b required=01110", {RegWriteE, MemWriteE, ALUControlE}); end
    ALUFlags = 4'b1111;
    step();
    n_checks++; if (FlagsE !== 4'b0110) begin n_fail++; $display("FAIL stall_single_write actual=%b required=0110", FlagsE); end
    $display("test_stall done: FlagsE=%b", FlagsE);
  endtask

  task automatic test_flush();
    set_d(0, 1, 1, 0, 1, 1, 0, 3'b111, 2'b11, 4'b1110);
    ALUFlags = 4'b0110;
    step();
    n_checks++; if (BranchTakenE !== 1'b1) begin n_fail++; $display("FAIL flush_setup_branch actual=%b required=1", BranchTakenE); end
    StallE = 1'b1; FlushE = 1'b1;
    ALUFlags = 4'b1000;
    step();
    n_checks++; if ({PCSrcE, RegWriteE, MemWriteE, MemtoRegE, ALUSrcE, BranchTakenE} !== 6'b000000)
      begin n_fail++; $display("FAIL flush_stall_bubble actual=%b required=000000", {PCSrcE, RegWriteE, MemWriteE, MemtoRegE, ALUSrcE, BranchTakenE}); end
    n_checks++; if (ALUControlE !== 3'b000) begin n_fail++; $display("FAIL flush_aluctl actual=%b required=000", ALUControlE); end
    n_checks++; if (CondExE !== 1'b1) begin n_fail++; $display("FAIL flush_bubble_cond actual=%b required=1", CondExE); end
    n_checks++; if (FlagsE !== 4'b0110) begin n_fail++; $display("FAIL flush_stall_flags actual=%b required=0110", FlagsE); end
    StallE = 1'b0; FlushE = 1'b0;
    step();                                 // recapture the flag-writing word
    FlushE = 1'b1;
    step();
    n_checks++; if (FlagsE !== 4'b1000) begin n_fail++; $display("FAIL flush_flag_write actual=%b required=1000", FlagsE); end
    n_checks++; if (BranchTakenE !== 1'b0) begin n_fail++; $display("FAIL flush_branch actual=%b required=0", BranchTakenE); end
    FlushE = 1'b0;
    $display("test_flush done: FlagsE=%b", FlagsE);
  endtask

  task automatic test_halt();
    set_d(0, 1, 0, 0, 0, 0, 1, 3'b000, 2'b00, 4'b1110);
    step();
    n_checks++; if (HaltE !== 1'b0) begin n_fail++; $display("FAIL halt_before actual=%b required=0", HaltE); end
    n_checks++; if (RegWriteE !== 1'b1) begin n_fail++; $display("FAIL halt_stuck_regwrite actual=%b required=1", RegWriteE); end
    set_d(1, 1, 0, 1, 1, 0, 0, 3'b001, 2'b11, 4'b1110);
    ALUFlags = 4'b0011;
    step();
    n_checks++; if (HaltE !== 1'b1) begin n_fail++; $display("FAIL halt_set actual=%b required=1", HaltE); end
    for (int i = 0; i < 3; i++) begin
      n_checks++; if ({PCSrcE, RegWriteE, MemWriteE, BranchTakenE} !== 4'b0000) begin n_fail++; $display("FAIL halt_gated cyc=%0d actual=%b required=0000", i, {PCSrcE, RegWriteE, MemWriteE, BranchTakenE}); end
      n_checks++; if (FlagsE !== 4'b1000) begin n_fail++; $display("FAIL halt_flags cyc=%0d actual=%b required=1000", i, FlagsE); end
      step();
      n_checks++; if (HaltE !== 1'b1) begin n_fail++; $display("FAIL halt_sticky cyc=%0d actual=%b required=1", i, HaltE); end
    end
    #2 rst_n = 1'b0;
    #1;
    n_checks++; if (HaltE !== 1'b0) begin n_fail++; $display("FAIL halt_reset actual=%b required=0", HaltE); end
    #2 rst_n = 1'b1;
    step();
    n_checks++; if ({RegWriteE, MemWriteE, PCSrcE, BranchTakenE} !== 4'b1111) begin n_fail++; $display("FAIL halt_resume actual=%b required=1111", {RegWriteE, MemWriteE, PCSrcE, BranchTakenE}); end
    $display("test_halt done: HaltE=%b", HaltE);
  endtask

  initial begin
    rst_n = 1'b0; StallE = 1'b0; FlushE = 1'b0; ALUFlags = 4'b0000;
    set_d(0, 0, 0, 0, 0, 0, 0, 3'b000, 2'b00, 4'b1110);
    #12 rst_n = 1'b1;
    test_reset();
    test_cond_gating();
    test_flags();
    test_stall();
    test_flush();
    test_halt();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
